// File: rtl/vga_rx_if.sv
// ---------------------------------------------------------------------------
// vga_rx_if
// Bundles the sampled VGA stream (hs, vs, rgb) and the recovered pixel/status
// outputs of vga_rx.
//   master : stream source / consumer side (drives hs, vs, rgb)
//   slave  : vga_rx side (drives pix_*, frame_start, locked, err)
// Signals:
//   hs, vs       horizontal / vertical sync, active-high pulses
//   rgb[11:0]    pixel color {R[3:0],G[3:0],B[3:0]}
//   pix_valid    one-clock strobe qualifying pix_x / pix_y / pix_rgb
//   pix_x/pix_y  active column / row
//   pix_rgb      captured color
//   frame_start  one-clock pulse per VS rising edge
//   locked       timing lock status
//   err          one-clock pulse per timing mismatch while acquiring/locked
// ---------------------------------------------------------------------------
interface vga_rx_if;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_rgb;
    logic        frame_start;
    logic        locked;
    logic        err;

    modport master (
        output hs, vs, rgb,
        input  pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err
    );

    modport slave (
        input  hs, vs, rgb,
        output pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err
    );
endinterface

// File: rtl/vga_rx.sv
// ---------------------------------------------------------------------------
// vga_rx
// Receive side of the VGA display path. Registers the incoming HS/VS/RGB
// stream, tracks line/frame timing with phase/column/line counters, locks
// onto the frame timing after LOCK_FRAMES consecutive good frames and then
// emits one strobe per active pixel with its coordinates and color.
// Ports:
//   clk   system clock (same clock and pixel-strobe ratio as the source)
//   rst   synchronous reset, active low
//   bus   vga_rx_if.slave: hs/vs/rgb in; pix_valid, pix_x, pix_y, pix_rgb,
//         frame_start, locked, err out (all outputs registered)
// ---------------------------------------------------------------------------
module vga_rx #(
    parameter int CLKS_PER_PIX = 4,
    parameter int SAMPLE_PHASE = 2,
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int H_START      = 144,
    parameter int V_START      = 35,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic    clk,
    input  logic    rst,
    vga_rx_if.slave bus
);

    localparam int              PH_W       = (CLKS_PER_PIX > 1) ? $clog2(CLKS_PER_PIX) : 1;
    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(CLKS_PER_PIX - 1);
    localparam logic [PH_W-1:0] PH_ONE     = PH_W'(1);
    localparam logic [PH_W-1:0] PH_SAMPLE  = PH_W'(SAMPLE_PHASE);
    localparam logic [11:0]     LINE_LAST  = 12'(H_TOTAL * CLKS_PER_PIX - 1);
    localparam logic [11:0]     LCLK_MAX   = 12'hFFF;
    localparam logic [11:0]     LCLK_PRE   = 12'hFFE;
    localparam logic [9:0]      FRAME_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]      H_LO       = 10'(H_START);
    localparam logic [9:0]      H_HI       = 10'(H_START + H_ACTIVE);
    localparam logic [9:0]      V_LO       = 10'(V_START);
    localparam logic [9:0]      V_HI       = 10'(V_START + V_ACTIVE);
    localparam logic [7:0]      LOCK_N     = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Saturating 10-bit increment: position counters stick at 1023 instead
    // of wrapping so a missing sync never aliases back into the active area.
    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        logic [9:0] res;
        if (v == 10'h3FF) begin
            res = v;
        end else begin
            res = v + 10'd1;
        end
        return res;
    endfunction

    // input stage
    logic            r_hs_q;
    logic            r_hs_q2;
    logic            r_vs_q;
    logic            r_vs_q2;
    logic [11:0]     r_rgb_q;

    // timing counters
    logic [PH_W-1:0] r_phase;
    logic [9:0]      r_hcnt;
    logic [9:0]      r_vcnt;
    logic [11:0]     r_lclk;

    // lock FSM
    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_good_cnt;
    logic [7:0]      w_good_nxt;

    // outputs
    logic            r_pix_valid;
    logic [9:0]      r_pix_x;
    logic [9:0]      r_pix_y;
    logic [11:0]     r_pix_rgb;
    logic            r_frame_start;
    logic            r_locked;
    logic            r_err;

    logic            w_hs_rise;
    logic            w_vs_rise;
    logic            w_line_bad;
    logic            w_frame_bad;
    logic            w_los;
    logic            w_mismatch;
    logic            w_in_window;
    logic            w_pix_hit;

    assign w_hs_rise = r_hs_q & ~r_hs_q2;
    assign w_vs_rise = r_vs_q & ~r_vs_q2;

    // Checks run on the counter values just before the HS/VS rise clears them.
    assign w_line_bad  = w_hs_rise && (r_lclk != LINE_LAST);
    assign w_frame_bad = w_vs_rise && (r_vcnt != FRAME_LAST);
    // Fires only on the step into 4095, so a dead HS reports once per outage.
    assign w_los       = !w_hs_rise && (r_lclk == LCLK_PRE);
    assign w_mismatch  = w_line_bad || w_frame_bad || w_los;

    assign w_in_window = (r_phase == PH_SAMPLE)
                      && (r_hcnt >= H_LO) && (r_hcnt < H_HI)
                      && (r_vcnt >= V_LO) && (r_vcnt < V_HI);
    assign w_pix_hit   = (r_state == ST_LOCKED) && w_in_window;

    // Input register plus second sync stage for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hs_q  <= 1'b0;
            r_hs_q2 <= 1'b0;
            r_vs_q  <= 1'b0;
            r_vs_q2 <= 1'b0;
            r_rgb_q <= 12'h000;
        end else begin
            r_hs_q  <= bus.hs;
            r_hs_q2 <= r_hs_q;
            r_vs_q  <= bus.vs;
            r_vs_q2 <= r_vs_q;
            r_rgb_q <= bus.rgb;
        end
    end

    // Pixel phase and column counters, re-aligned on every HS rise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_phase <= '0;
            r_hcnt  <= 10'd0;
        end else if (w_hs_rise) begin
            r_phase <= '0;
            r_hcnt  <= 10'd0;
        end else if (r_phase == PH_LAST) begin
            r_phase <= '0;
            r_hcnt  <= sat_inc10(r_hcnt);
        end else begin
            r_phase <= r_phase + PH_ONE;
        end
    end

    // Line counter: VS rise clears it with priority over the HS increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vcnt <= 10'd0;
        end else if (w_vs_rise) begin
            r_vcnt <= 10'd0;
        end else if (w_hs_rise) begin
            r_vcnt <= sat_inc10(r_vcnt);
        end else begin
            r_vcnt <= r_vcnt;
        end
    end

    // Clocks since the last HS rise, saturating as the loss-of-signal marker.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lclk <= 12'd0;
        end else if (w_hs_rise) begin
            r_lclk <= 12'd0;
        end else if (r_lclk != LCLK_MAX) begin
            r_lclk <= r_lclk + 12'd1;
        end else begin
            r_lclk <= r_lclk;
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
        end
    end

    // Lock FSM next state: any mismatch outside SEARCH restarts acquisition;
    // a VS rise counts as a good frame only when nothing failed on that clock.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_rise) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_good_nxt  = 8'd0;
                end else begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_ACQUIRE: begin
                if (w_mismatch) begin
                    w_state_nxt = ST_SEARCH;
                    w_good_nxt  = 8'd0;
                end else if (w_vs_rise) begin
                    w_good_nxt = r_good_cnt + 8'd1;
                    if ((r_good_cnt + 8'd1) >= LOCK_N) begin
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_state_nxt = ST_ACQUIRE;
                    end
                end else begin
                    w_state_nxt = ST_ACQUIRE;
                end
            end
            ST_LOCKED: begin
                if (w_mismatch) begin
                    w_state_nxt = ST_SEARCH;
                    w_good_nxt  = 8'd0;
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
                w_good_nxt  = 8'd0;
            end
        endcase
    end

    // Registered outputs; locked follows the next state so it rises together
    // with the FSM entering LOCKED and falls together with err.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pix_valid   <= 1'b0;
            r_pix_x       <= 10'd0;
            r_pix_y       <= 10'd0;
            r_pix_rgb     <= 12'h000;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_frame_start <= w_vs_rise;
            r_err         <= w_mismatch && (r_state != ST_SEARCH);
            r_locked      <= (w_state_nxt == ST_LOCKED);
            r_pix_valid   <= w_pix_hit;
            if (w_pix_hit) begin
                r_pix_x   <= r_hcnt - H_LO;
                r_pix_y   <= r_vcnt - V_LO;
                r_pix_rgb <= r_rgb_q;
            end
        end
    end

    assign bus.pix_valid   = r_pix_valid;
    assign bus.pix_x       = r_pix_x;
    assign bus.pix_y       = r_pix_y;
    assign bus.pix_rgb     = r_pix_rgb;
    assign bus.frame_start = r_frame_start;
    assign bus.locked      = r_locked;
    assign bus.err         = r_err;

endmodule

// File: tb/tb_vga_rx.sv
// ---------------------------------------------------------------------------
// tb_vga_rx
// Drives a scaled-down VGA timing (40x12 pixels per frame, 24x6 active) into
// vga_rx and checks lock behaviour, pixel recovery, short lines, loss of
// signal and bad frames. The source keeps a queue of the pixels it expects
// back (coordinate, color and arrival clock) whenever the receiver should be
// locked; everything unexpected or out of place counts against the stream.
// ---------------------------------------------------------------------------
module tb_vga_rx;
    localparam int CPP   = 4;
    localparam int SPH   = 2;
    localparam int HT    = 40;
    localparam int VT    = 12;
    localparam int HS0   = 8;
    localparam int VS0   = 3;
    localparam int HA    = 24;
    localparam int VA    = 6;
    localparam int LOCKN = 2;
    localparam int LINE  = HT * CPP;
    localparam int HS_W  = 4 * CPP;
    localparam int NPIX  = HA * VA;

    logic clk = 1'b0;
    logic rst = 1'b0;

    vga_rx_if bus();

    vga_rx #(
        .CLKS_PER_PIX(CPP), .SAMPLE_PHASE(SPH), .H_TOTAL(HT), .V_TOTAL(VT),
        .H_START(HS0), .V_START(VS0), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .LOCK_FRAMES(LOCKN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // stream monitor state
    int          cyc = 0;
    int          cur_line = -1;
    int          cur_t = 0;
    int          fs_cnt, fs_bad, err_cnt, err_locked, locked_cyc, pv_cnt, pix_bad;
    logic        fs_locked_last;
    logic [31:0] first_pix, last_pix, bad_got, bad_exp;
    logic [63:0] exp_q[$];

    task automatic clear_mon();
        fs_cnt = 0; fs_bad = 0; err_cnt = 0; err_locked = 0; locked_cyc = 0;
        pv_cnt = 0; pix_bad = 0; fs_locked_last = 1'b0;
        first_pix = 32'd0; last_pix = 32'd0; bad_got = 32'd0; bad_exp = 32'd0;
        exp_q.delete();
    endtask

    // One clock: pins already set, sample outputs 1 time unit after the edge.
    task automatic step();
        logic [63:0] e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        obs = {bus.pix_x, bus.pix_y, bus.pix_rgb};
        if (bus.frame_start === 1'b1) begin
            fs_cnt++;
            fs_locked_last = bus.locked;
            if (!(cur_line == 0 && cur_t == 1)) fs_bad++;
        end
        if (bus.err === 1'b1) begin
            err_cnt++;
            if (bus.locked !== 1'b0) err_locked++;
        end
        if (bus.locked === 1'b1) locked_cyc++;
        if (bus.pix_valid === 1'b1) begin
            pv_cnt++;
            if (pv_cnt == 1) first_pix = obs;
            last_pix = obs;
            if (exp_q.size() == 0) begin
                if (pix_bad == 0) begin bad_got = obs; bad_exp = 32'hFFFFFFFF; end
                pix_bad++;
            end else begin
                e = exp_q.pop_front();
                if (e[63:32] != 32'(cyc) || e[31:0] !== obs) begin
                    if (pix_bad == 0) begin bad_got = obs; bad_exp = e[31:0]; end
                    pix_bad++;
                end
            end
        end
        cyc++;
    endtask

    // Source model: HS high for the first HS_W clocks of each line, VS high on
    // lines 0-1. The receiver captures the pin value one clock after phase
    // SPH of each pixel starts, so only that clock carries the real pixel in
    // random mode; the pattern mode holds {x,y,A} for the whole pixel.
    task automatic drive_frame(input int n_lines, input int short_line, input int short_len,
                               input bit push, input bit pattern);
        logic [11:0] c;
        int len, col, row;
        bit act;
        for (int l = 0; l < n_lines; l++) begin
            len = (l == short_line) ? short_len : LINE;
            for (int t = 0; t < len; t++) begin
                row = l - VS0;
                col = (t / CPP) - HS0;
                act = (row >= 0) && (row < VA) && (col >= 0) && (col < HA);
                if (pattern && act) c = {col[3:0], row[3:0], 4'hA};
                else c = 12'($urandom);
                bus.hs = (t < HS_W);
                bus.vs = (l < 2);
                bus.rgb = c;
                cur_line = l;
                cur_t = t;
                if (push && act && (t % CPP) == (SPH + 1) && (short_line < 0 || l <= short_line))
                    exp_q.push_back({32'(cyc + 1), 10'(col), 10'(row), c});
                step();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.hs = 1'($urandom); bus.vs = 1'($urandom); bus.rgb = 12'($urandom);
            cur_line = -1;
            step();
        end
        n_checks++; if (bus.pix_valid !== 1'b0) $display("FAIL reset_pix_valid: got %b want 0", bus.pix_valid); else n_pass++;
        n_checks++; if (bus.pix_x !== 10'd0) $display("FAIL reset_pix_x: got %0d want 0", bus.pix_x); else n_pass++;
        n_checks++; if (bus.pix_y !== 10'd0) $display("FAIL reset_pix_y: got %0d want 0", bus.pix_y); else n_pass++;
        n_checks++; if (bus.pix_rgb !== 12'h000) $display("FAIL reset_pix_rgb: got %h want 000", bus.pix_rgb); else n_pass++;
        n_checks++; if (bus.frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b want 0", bus.frame_start); else n_pass++;
        n_checks++; if (bus.locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", bus.locked); else n_pass++;
        n_checks++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err); else n_pass++;
        bus.hs = 1'b0; bus.vs = 1'b0; bus.rgb = 12'h000;
        rst = 1'b1;
        clear_mon();
    endtask

    task automatic test_lock_and_pattern();
        clear_mon();
        drive_frame(VT, -1, 0, 1'b0, 1'b0);
        drive_frame(VT, -1, 0, 1'b0, 1'b0);
        n_checks++; if (fs_cnt !== 2) $display("FAIL lock_fs_count: got %0d want 2", fs_cnt); else n_pass++;
        n_checks++; if (locked_cyc !== 0) $display("FAIL lock_early: got %0d locked clocks want 0", locked_cyc); else n_pass++;
        drive_frame(VT, -1, 0, 1'b1, 1'b1);
        n_checks++; if (fs_locked_last !== 1'b1) $display("FAIL lock_third_vs: got %b want 1", fs_locked_last); else n_pass++;
        n_checks++; if (fs_cnt !== 3 || fs_bad !== 0) $display("FAIL lock_fs_timing: got count %0d misplaced %0d want 3/0", fs_cnt, fs_bad); else n_pass++;
        n_checks++; if (err_cnt !== 0) $display("FAIL lock_err: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (pv_cnt !== NPIX) $display("FAIL pattern_count: got %0d want %0d", pv_cnt, NPIX); else n_pass++;
        n_checks++; if (pix_bad !== 0) $display("FAIL pattern_data: got %0d bad (first %h vs %h) want 0", pix_bad, bad_got, bad_exp); else n_pass++;
        n_checks++; if (first_pix !== {10'd0, 10'd0, 12'h00A}) $display("FAIL pattern_first: got %h want %h", first_pix, {10'd0, 10'd0, 12'h00A}); else n_pass++;
        n_checks++; if (last_pix !== {10'd23, 10'd5, 12'h75A}) $display("FAIL pattern_last: got %h want %h", last_pix, {10'd23, 10'd5, 12'h75A}); else n_pass++;
    endtask

    task automatic test_back_to_back_random();
        clear_mon();
        drive_frame(VT, -1, 0, 1'b1, 1'b0);
        drive_frame(VT, -1, 0, 1'b1, 1'b0);
        n_checks++; if (pv_cnt !== 2 * NPIX) $display("FAIL random_count: got %0d want %0d", pv_cnt, 2 * NPIX); else n_pass++;
        n_checks++; if (pix_bad !== 0) $display("FAIL random_data: got %0d bad (first %h vs %h) want 0", pix_bad, bad_got, bad_exp); else n_pass++;
        n_checks++; if (err_cnt !== 0 || bus.locked !== 1'b1) $display("FAIL random_status: got err %0d locked %b want 0/1", err_cnt, bus.locked); else n_pass++;
    endtask

    task automatic relock_check(input string tag);
        clear_mon();
        drive_frame(VT, -1, 0, 1'b0, 1'b0);
        drive_frame(VT, -1, 0, 1'b0, 1'b0);
        n_checks++; if (locked_cyc !== 0 || pv_cnt !== 0) $display("FAIL %s_relock_early: got locked %0d pixels %0d want 0/0", tag, locked_cyc, pv_cnt); else n_pass++;
        n_checks++; if (err_cnt !== 0) $display("FAIL %s_relock_err: got %0d want 0", tag, err_cnt); else n_pass++;
        clear_mon();
        drive_frame(VT, -1, 0, 1'b1, 1'b0);
        n_checks++; if (fs_locked_last !== 1'b1) $display("FAIL %s_relock: got %b want 1", tag, fs_locked_last); else n_pass++;
        n_checks++; if (pv_cnt !== NPIX || pix_bad !== 0) $display("FAIL %s_relock_pixels: got %0d pixels %0d bad want %0d/0", tag, pv_cnt, pix_bad, NPIX); else n_pass++;
    endtask

    task automatic test_short_line();
        clear_mon();
        drive_frame(VT, 5, LINE - 4, 1'b1, 1'b0);
        n_checks++; if (err_cnt !== 1) $display("FAIL short_err_count: got %0d want 1", err_cnt); else n_pass++;
        n_checks++; if (err_locked !== 0 || bus.locked !== 1'b0) $display("FAIL short_locked: got err-while-locked %0d locked %b want 0/0", err_locked, bus.locked); else n_pass++;
        n_checks++; if (pv_cnt !== HA * 3 || pix_bad !== 0) $display("FAIL short_pixels: got %0d pixels %0d bad want %0d/0", pv_cnt, pix_bad, HA * 3); else n_pass++;
        relock_check("short");
    endtask

    task automatic test_loss_of_signal();
        int err_at;
        err_at = -1;
        clear_mon();
        for (int i = 0; i < 5000; i++) begin
            bus.hs = 1'b0; bus.vs = 1'b0; bus.rgb = 12'($urandom);
            cur_line = -1;
            step();
            if (err_cnt == 1 && err_at < 0) err_at = i;
        end
        n_checks++; if (err_cnt !== 1) $display("FAIL los_err_count: got %0d want 1", err_cnt); else n_pass++;
        // Last HS rise was at the start of the final 160-clock line; lclk hits 4095 4096 clocks later.
        n_checks++; if (err_at !== 4096 - LINE) $display("FAIL los_err_time: got %0d want %0d", err_at, 4096 - LINE); else n_pass++;
        n_checks++; if (err_locked !== 0 || bus.locked !== 1'b0) $display("FAIL los_locked: got err-while-locked %0d locked %b want 0/0", err_locked, bus.locked); else n_pass++;
        relock_check("los");
    endtask

    task automatic test_bad_frame();
        clear_mon();
        drive_frame(5, -1, 0, 1'b1, 1'b0);
        n_checks++; if (bus.locked !== 1'b1) $display("FAIL midreset_pre: got %b want 1", bus.locked); else n_pass++;
        rst = 1'b0;
        cur_line = -1;
        step();
        n_checks++; if (bus.locked !== 1'b0 || bus.pix_valid !== 1'b0) $display("FAIL midreset_drop: got locked %b pix_valid %b want 0/0", bus.locked, bus.pix_valid); else n_pass++;
        rst = 1'b1;
        clear_mon();
        drive_frame(VT, -1, 0, 1'b0, 1'b0);
        drive_frame(VT - 1, -1, 0, 1'b0, 1'b0);
        drive_frame(VT, -1, 0, 1'b0, 1'b0);
        drive_frame(VT, -1, 0, 1'b0, 1'b0);
        drive_frame(VT, -1, 0, 1'b0, 1'b0);
        n_checks++; if (err_cnt !== 1) $display("FAIL badframe_err: got %0d want 1", err_cnt); else n_pass++;
        n_checks++; if (locked_cyc !== 0 || pv_cnt !== 0) $display("FAIL badframe_nolock: got locked %0d pixels %0d want 0/0", locked_cyc, pv_cnt); else n_pass++;
        clear_mon();
        drive_frame(VT, -1, 0, 1'b1, 1'b0);
        n_checks++; if (fs_locked_last !== 1'b1) $display("FAIL badframe_relock: got %b want 1", fs_locked_last); else n_pass++;
        n_checks++; if (pv_cnt !== NPIX || pix_bad !== 0) $display("FAIL badframe_pixels: got %0d pixels %0d bad want %0d/0", pv_cnt, pix_bad, NPIX); else n_pass++;
    endtask

    initial begin
        bus.hs = 1'b0; bus.vs = 1'b0; bus.rgb = 12'h000;
        clear_mon();
        test_reset();
        test_lock_and_pattern();
        test_back_to_back_random();
        test_short_line();
        test_loss_of_signal();
        test_bad_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_rx.md
# vga_rx

Receive-side counterpart of the board VGA generator: samples the HS/VS/12-bit RGB stream produced by the display path, locks onto the 640x480 frame timing and recovers per-pixel coordinates and color. Used for loopback self-check of the display path and as the front end for frame capture or CRC logic. It shares the display path's system clock and pixel-strobe ratio.

## Interface
- CLKS_PER_PIX, 4, system clocks per pixel; power of two.
- SAMPLE_PHASE, 2, pixel-phase index (0..CLKS_PER_PIX-1) at which RGB is captured.
- H_TOTAL, 800, pixels per line.
- V_TOTAL, 525, lines per frame.
- H_START, 144, first active pixel index after the HS rising edge.
- V_START, 35, first active line index after the VS rising edge.
- H_ACTIVE / V_ACTIVE, 640 / 480, active width / height.
- LOCK_FRAMES, 2, consecutive good frames required for lock.

- clk  in  1  system clock
- rst  in  1  synchronous reset, active low
- hs  in  1  horizontal sync, active-high pulse
- vs  in  1  vertical sync, active-high pulse
- rgb  in  12  pixel color {R[3:0],G[3:0],B[3:0]}
- pix_valid  out  1  one-clk strobe: pix_x/pix_y/pix_rgb valid
- pix_x  out  10  active column 0..639
- pix_y  out  10  active row 0..479
- pix_rgb  out  12  captured color
- frame_start  out  1  one-clk pulse on each VS rising edge
- locked  out  1  timing lock status
- err  out  1  one-clk pulse on any timing mismatch

## Operation
- Input stage: hs, vs, rgb registered once (hs_q, vs_q, rgb_q); hs_q/vs_q delayed again for edge detect. HS rise = hs_q & ~hs_q2; same for VS.
- Counters: phase (log2 CLKS_PER_PIX bits), hcnt (10 b), vcnt (10 b), lclk (12 b, clocks since last HS rise, saturates 4095).
- On HS rise: phase<=0, hcnt<=0, lclk<=0, vcnt<=vcnt+1. On VS rise (coincident with HS rise in valid timing): vcnt<=0 takes priority over increment.
- Otherwise phase increments and wraps; hcnt increments when phase wraps to 0. hcnt/vcnt saturate at 1023, never wrap.
- Line check at each HS rise: lclk must equal H_TOTAL*CLKS_PER_PIX-1 (3199). Frame check at each VS rise: vcnt must equal V_TOTAL-1 (524). lclk reaching 4095 = loss-of-signal mismatch.
- FSM SEARCH -> ACQUIRE -> LOCKED:
  - SEARCH: wait for VS rise; then ACQUIRE, good-frame count 0.
  - ACQUIRE: each VS rise with no mismatch since previous VS rise increments count; at LOCK_FRAMES go LOCKED.
  - LOCKED: any mismatch -> SEARCH.
  - Any mismatch in ACQUIRE -> SEARCH. A VS rise that also fails the frame check counts as mismatch, not good frame.
- err pulses on every mismatch in ACQUIRE or LOCKED; mismatches in SEARCH are silent. Loss-of-signal reports err once, not every clock, until next HS rise.
- pix_valid only in LOCKED, at phase==SAMPLE_PHASE, H_START<=hcnt<H_START+H_ACTIVE, V_START<=vcnt<V_START+V_ACTIVE; pix_x=hcnt-H_START, pix_y=vcnt-V_START, pix_rgb=rgb_q.
- frame_start pulses on every VS rise regardless of lock.

## Timing
- Reset (rst=0 at a clk edge): FSM SEARCH, all counters 0, pix_valid=0, pix_x=0, pix_y=0, pix_rgb=0, frame_start=0, locked=0, err=0. Reset mid-frame drops lock immediately; relock needs a fresh VS rise plus LOCK_FRAMES frames.
- Latency: pin to output 2 clk (input register + output register); pix_rgb equals the rgb pin value sampled at the corresponding edge.
- frame_start and err are registered, asserted 2 clk after the triggering pin edge, width exactly 1 clk.
- locked rises in the same cycle the FSM enters LOCKED; falls 1 clk after mismatch detection, same cycle as err.
- Steady state: exactly 640 pix_valid per active line, 307200 per frame, spaced CLKS_PER_PIX clk.

## Test plan
- Reset: drive rst=0 for 3 clk with toggling inputs -> all outputs 0, locked=0.
- Lock: standard 800x525, CLKS_PER_PIX=4 source -> frame_start at each VS; locked=1 at the 3rd VS rise (SEARCH entry + 2 good frames); no err.
- Pixel recovery: source rgb = {pix_x[3:0], pix_y[3:0], 4'hA} -> 307200 pix_valid per frame, first (0,0,12'h00A), last (639,479,12'hFFA), every value matches.
- Short line: in a locked stream, one line 3196 clk -> err one pulse, locked=0, no pix_valid until relock 2 frames later.
- Loss of signal: hold hs=0 for 5000 clk while locked -> single err at lclk=4095, locked=0; restoring timing relocks.
- Bad frame: 524 lines in ACQUIRE -> err, back to SEARCH, good-frame count restarts.
